pc_reg: RTL and testbench

//   Program-counter register for the single-cycle RV32 core datapath.
//   - Captures next-PC value `oldpc` (from the next-PC mux) on every rising clk edge.
//   - Presents it as current PC `newpc` to instruction memory and the PC+4 adder.
//   - Also provides sequential next address and alignment status.

---
 rtl/pc_reg.sv | 62 ++++++
 tb/tb_pc_reg.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_reg.sv
// Program-counter register for the single-cycle RV32 datapath: current PC, PC+4, alignment status, load count.
// Optional PC_ALIGN_EN: forces loaded PC word-aligned, ties misaligned low, adds sticky align_fault output.
module pc_reg #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] oldpc,
  output logic [XLEN-1:0] newpc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned,
`ifdef PC_ALIGN_EN
  output logic            align_fault,
`endif
  output logic [31:0]     retired_cnt
);

  logic [XLEN-1:0] load_val;

`ifdef PC_ALIGN_EN
  always_comb begin
    load_val = {oldpc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_fault <= 1'b0;
    end else if (oldpc[1:0] != 2'b00) begin
      align_fault <= 1'b1;
    end
  end

  always_comb begin
    misaligned = 1'b0;
  end
`else
  always_comb begin
    load_val = oldpc;
  end

  always_comb begin
    misaligned = (newpc[1:0] != 2'b00);
  end
`endif

  // Every non-reset edge loads; there is no stall path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      newpc       <= RESET_VECTOR;
      retired_cnt <= '0;
    end else begin
      newpc       <= load_val;
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  always_comb begin
    pc_plus4 = newpc + XLEN'(4);
  end

endmodule

// File: tb/tb_pc_reg.sv
// Directed self-checking bench for pc_reg; follows PC_ALIGN_EN if defined at build time.
module tb_pc_reg;

  logic        clk;
  logic        rst;
  logic [31:0] oldpc;
  logic [31:0] newpc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic [31:0] retired_cnt;
`ifdef PC_ALIGN_EN
  logic        align_fault;
`endif

  int n_assert;
  int n_fail;

  pc_reg #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .oldpc      (oldpc),
    .newpc      (newpc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned),
`ifdef PC_ALIGN_EN
    .align_fault(align_fault),
`endif
    .retired_cnt(retired_cnt)
  );

  // One full clock period; leaves clk low so samples sit mid-low-phase.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rst      = 1'b0;
    oldpc    = 32'h0;

    // Reset with no clock edges
    #1 rst = 1'b1;
    #1;
    check("reset_newpc", newpc, 32'h0);
    check("reset_cnt", retired_cnt, 32'd0);
    check("reset_plus4", pc_plus4, 32'h4);
    check("reset_misaligned", misaligned, 1'b0);

    // Reset held across five edges
    oldpc = 32'h40;
    for (int i = 0; i < 5; i++) tick();
    check("rsthold_newpc", newpc, 32'h0);
    check("rsthold_cnt", retired_cnt, 32'd0);

    // Release and sequential loads
    #2 rst = 1'b0;
    #1;
    check("release_nolod", newpc, 32'h0);
    for (int i = 0; i < 10; i++) begin
      oldpc = 32'(4 * i);
      tick();
      check("seq_newpc", newpc, 32'(4 * i));
      check("seq_cnt", retired_cnt, 32'(i + 1));
      check("seq_plus4", pc_plus4, 32'(4 * i + 4));
    end
    check("seq_final_newpc", newpc, 32'd36);
    check("seq_final_cnt", retired_cnt, 32'd10);

    // Asynchronous mid-run reset
    oldpc = 32'h100;
    tick();
    check("pre_rst_newpc", newpc, 32'h100);
    check("pre_rst_cnt", retired_cnt, 32'd11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_newpc", newpc, 32'h0);
    check("async_rst_cnt", retired_cnt, 32'd0);
    oldpc = 32'h200;
    tick();
    check("rst_override_newpc", newpc, 32'h0);
    #2 rst = 1'b0;

    // Wrap of pc_plus4
    oldpc = 32'hFFFF_FFFC;
    tick();
    check("wrap_newpc", newpc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    check("wrap_cnt", retired_cnt, 32'd1);

    // Misaligned load
    oldpc = 32'h6;
    tick();
`ifdef PC_ALIGN_EN
    check("mis_newpc", newpc, 32'h4);
    check("mis_flag", misaligned, 1'b0);
    check("mis_fault", align_fault, 1'b1);
    check("mis_plus4", pc_plus4, 32'h8);
    oldpc = 32'h8;
    tick();
    check("fault_sticky", align_fault, 1'b1);
    check("aligned_newpc", newpc, 32'h8);
    #2 rst = 1'b1;
    #1;
    check("fault_cleared", align_fault, 1'b0);
    #2 rst = 1'b0;
`else
    check("mis_newpc", newpc, 32'h6);
    check("mis_flag", misaligned, 1'b1);
    check("mis_plus4", pc_plus4, 32'hA);
    oldpc = 32'h8;
    tick();
    check("aligned_flag", misaligned, 1'b0);
    check("aligned_newpc", newpc, 32'h8);
`endif
    check("final_cnt_or_reset", retired_cnt,
`ifdef PC_ALIGN_EN
          32'd0
`else
          32'd3
`endif
    );

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
